accum_seq_ctrl: RTL and testbench

ACCUM_SEQ_CTRL -- requirements
Module: accum_seq_ctrl

---
 rtl/accum_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_accum_seq_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: sequences multi-pass accumulation jobs onto a banked
// accumulator slot, then reads back the result rows into a small readout
// FIFO.
//
// A job is started by a start pulse in IDLE. The pulse latches base row,
// row count, pass count, zone and bank mask.
// - Pass 0 streams operands as WRITE commands.
// - Passes 1..N-1 stream operands as ACCUM commands.
// - The rows are then issued as READ commands.
// READ issue is throttled so that outstanding reads plus buffered results
// never exceed RD_FIFO_DEPTH. Read data returns in order on rsp_valid.
//
// Optional feature: define ACCUM_SEQ_PERF_EN to enable the 32-bit saturating
// perf_busy_cycles / perf_stall_cycles counters. Without it both outputs are
// tied to zero.
//
// Ports (W = NUM_BANKS*DATA_WIDTH):
//   clk, rstn                      clock, synchronous active-low reset
//   start, cfg_*                   job launch and configuration
//   busy, done                     job active level, one-cycle completion pulse
//   in_valid/in_ready/in_data      operand stream (LOAD and ACCUM passes)
//   cmd_valid/cmd_ready/cmd_*      command channel to the accumulator slot
//   rsp_valid/rsp_data             in-order read data return
//   out_valid/out_ready/out_data   result stream, out_last on final row
//   perf_busy_cycles/perf_stall_cycles  performance counters
//
// RD_FIFO_DEPTH must be a power of two, 2 or larger.
module accum_seq_ctrl #(
  parameter int NUM_BANKS     = 4,
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 64,
  parameter int ZONE_WIDTH    = 2,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           cfg_base,
  input  logic [ADDR_WIDTH:0]             cfg_len,
  input  logic [7:0]                      cfg_passes,
  input  logic [ZONE_WIDTH-1:0]           cfg_zone,
  input  logic [NUM_BANKS-1:0]            cfg_bank_mask,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] in_data,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [1:0]                      cmd_op,
  output logic [ADDR_WIDTH-1:0]           cmd_addr,
  output logic [ZONE_WIDTH-1:0]           cmd_zone,
  output logic [NUM_BANKS-1:0]            cmd_bank_mask,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] cmd_wdata,
  input  logic                            rsp_valid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rsp_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  output logic [31:0]                     perf_busy_cycles,
  output logic [31:0]                     perf_stall_cycles
);

  localparam int W  = NUM_BANKS * DATA_WIDTH;
  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0]          OP_WRITE = 2'b00;
  localparam logic [1:0]          OP_ACCUM = 2'b01;
  localparam logic [1:0]          OP_READ  = 2'b10;
  localparam logic [ADDR_WIDTH:0] ROW_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]       PTR_ONE  = PW'(1);
  localparam logic [CW:0]         DEPTH_C  = (CW+1)'(RD_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Latched job configuration
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [7:0]            passes_q;
  logic [ZONE_WIDTH-1:0] zone_q;
  logic [NUM_BANKS-1:0]  mask_q;

  // Sequencing counters
  logic [ADDR_WIDTH:0]   row_q;
  logic [7:0]            pass_q;
  logic [ADDR_WIDTH:0]   res_q;
  logic [CW-1:0]         outst_q;

  // Readout FIFO
  logic [W-1:0]          mem [RD_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_q;

  logic [ADDR_WIDTH:0]   len_m1;
  logic                  row_last, pass_last;
  logic                  fire, wa_fire, rd_fire, push, pop, rd_room;

  assign len_m1    = len_q - ROW_ONE;
  assign row_last  = (row_q == len_m1);
  assign pass_last = (pass_q == passes_q - 8'd1);

  assign fire    = cmd_valid && cmd_ready;
  assign wa_fire = fire && (state == S_LOAD || state == S_ACCUM);
  assign rd_fire = fire && (state == S_READ);

  // Returns with nothing outstanding are strays (e.g. after a mid-job reset).
  assign push    = rsp_valid && (outst_q != '0);
  assign pop     = out_valid && out_ready;

  // Reserve a FIFO slot for every read in flight so returns never overflow.
  assign rd_room = (({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C);

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign cmd_zone      = zone_q;
  assign cmd_bank_mask = mask_q;

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid && (res_q == len_m1);

  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    in_ready  = 1'b0;
    cmd_op    = OP_WRITE;
    cmd_addr  = '0;
    cmd_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD, S_ACCUM: begin
        cmd_op    = (state == S_LOAD) ? OP_WRITE : OP_ACCUM;
        cmd_valid = in_valid;
        in_ready  = cmd_ready;
        cmd_wdata = in_data;
        cmd_addr  = base_q + row_q[ADDR_WIDTH-1:0];
        if (wa_fire && row_last) begin
          state_nxt = pass_last ? S_READ : S_ACCUM;
        end
      end
      S_READ: begin
        cmd_op    = OP_READ;
        cmd_valid = rd_room;
        cmd_addr  = base_q + row_q[ADDR_WIDTH-1:0];
        if (rd_fire && row_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && cnt_q == CNT_ONE && outst_q == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      passes_q <= '0;
      zone_q   <= '0;
      mask_q   <= '0;
      row_q    <= '0;
      pass_q   <= '0;
      res_q    <= '0;
      outst_q  <= '0;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nxt;

      // Row counter wraps at the end of every pass, including the read pass.
      if (wa_fire) begin
        if (row_last) begin
          row_q  <= '0;
          pass_q <= pass_q + 8'd1;
        end else begin
          row_q <= row_q + ROW_ONE;
        end
      end
      if (rd_fire) begin
        row_q <= row_last ? '0 : row_q + ROW_ONE;
      end

      case ({rd_fire, push})
        2'b10:   outst_q <= outst_q + CNT_ONE;
        2'b01:   outst_q <= outst_q - CNT_ONE;
        default: outst_q <= outst_q;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase

      if (pop) res_q <= res_q + ROW_ONE;

      if (state == S_IDLE && start) begin
        base_q   <= cfg_base;
        len_q    <= cfg_len;
        passes_q <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
        zone_q   <= cfg_zone;
        mask_q   <= cfg_bank_mask;
        row_q    <= '0;
        pass_q   <= '0;
        res_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rsp_data;
  end

`ifdef ACCUM_SEQ_PERF_EN
  logic [31:0] busy_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && busy_cnt != '1) busy_cnt <= busy_cnt + 32'd1;
      if (cmd_valid && !cmd_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_busy_cycles  = busy_cnt;
  assign perf_stall_cycles = stall_cnt;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Testbench for accum_seq_ctrl.
//
// The bench emulates the accumulator slot, which is a banked row memory
// with in-order read returns. It predicts every command and every result
// from the job parameters with plain arithmetic.
module tb_accum_seq_ctrl;

  localparam int NUM_BANKS     = 4;
  localparam int ADDR_WIDTH    = 9;
  localparam int DATA_WIDTH    = 64;
  localparam int ZONE_WIDTH    = 2;
  localparam int RD_FIFO_DEPTH = 4;
  localparam int W             = NUM_BANKS * DATA_WIDTH;
  localparam int ROWS          = 1 << ADDR_WIDTH;

  logic                  clk;
  logic                  rstn;
  logic                  start;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [ADDR_WIDTH:0]   cfg_len;
  logic [7:0]            cfg_passes;
  logic [ZONE_WIDTH-1:0] cfg_zone;
  logic [NUM_BANKS-1:0]  cfg_bank_mask;
  logic                  busy, done;
  logic                  in_valid, in_ready;
  logic [W-1:0]          in_data;
  logic                  cmd_valid, cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ZONE_WIDTH-1:0] cmd_zone;
  logic [NUM_BANKS-1:0]  cmd_bank_mask;
  logic [W-1:0]          cmd_wdata;
  logic                  rsp_valid;
  logic [W-1:0]          rsp_data;
  logic                  out_valid, out_ready, out_last;
  logic [W-1:0]          out_data;
  logic [31:0]           perf_busy_cycles, perf_stall_cycles;

  int errs   = 0;
  int checks = 0;
  int edges  = 0;

  logic [W-1:0] acc_mem [ROWS];
  logic [W-1:0] rspq_d [$];
  int           rspq_t [$];

  accum_seq_ctrl #(
    .NUM_BANKS(NUM_BANKS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ZONE_WIDTH(ZONE_WIDTH), .RD_FIFO_DEPTH(RD_FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
    .cfg_zone(cfg_zone), .cfg_bank_mask(cfg_bank_mask),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_zone(cmd_zone), .cmd_bank_mask(cmd_bank_mask),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] fixed_vec(input int r);
    logic [W-1:0] v;
    for (int b = 0; b < NUM_BANKS; b++) v[b*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(r + 1);
    return v;
  endfunction

  function automatic logic [W-1:0] bank_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    for (int k = 0; k < NUM_BANKS; k++)
      s[k*DATA_WIDTH +: DATA_WIDTH] = a[k*DATA_WIDTH +: DATA_WIDTH] + b[k*DATA_WIDTH +: DATA_WIDTH];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    in_valid  = 1'b0;
    cmd_ready = 1'b0;
    out_ready = 1'b0;
    rsp_valid = 1'b0;
  endtask

  // Runs one job to completion with randomized handshakes, checking every
  // command and result against the job arithmetic.
  task automatic run_job(input int base, input int len, input int passes, input int lat,
                         input int in_pct, input int cmd_pct, input int out_pct,
                         input int cmd_hold, input int out_hold, input bit fixed_ops,
                         output int reads_before_pop, output int cv_at_release,
                         output int busy_edges);
    int np, nstream, sidx, nwr, nac, nrd, ridx, e0, p, r, ea, eop, k;
    bit fin;
    logic [W-1:0] opq [$];
    logic [W-1:0] expv [$];
    logic [W-1:0] v;
    logic [ZONE_WIDTH-1:0] zone;
    logic [NUM_BANKS-1:0]  mask;

    np      = (passes == 0) ? 1 : passes;
    nstream = np * len;
    for (int i = 0; i < nstream; i++) opq.push_back(fixed_ops ? fixed_vec(i % len) : rand_vec());
    for (int rr = 0; rr < len; rr++) begin
      v = '0;
      for (int pp = 0; pp < np; pp++) v = bank_add(v, opq[pp*len + rr]);
      expv.push_back(v);
    end
    zone = ZONE_WIDTH'($urandom);
    mask = NUM_BANKS'($urandom);
    rspq_d.delete();
    rspq_t.delete();
    sidx = 0; nwr = 0; nac = 0; nrd = 0; ridx = 0; fin = 1'b0;
    reads_before_pop = -1; cv_at_release = -1; busy_edges = 0;

    idle_inputs();
    cfg_base      = ADDR_WIDTH'(base);
    cfg_len       = (ADDR_WIDTH+1)'(len);
    cfg_passes    = 8'(passes);
    cfg_zone      = zone;
    cfg_bank_mask = mask;
    start         = 1'b1;
    tick();
    e0 = edges;

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      // Noise on the launch inputs must be ignored while the job runs.
      start         = pct(12);
      cfg_base      = ADDR_WIDTH'($urandom);
      cfg_len       = (ADDR_WIDTH+1)'($urandom);
      cfg_passes    = 8'($urandom);
      cfg_zone      = ZONE_WIDTH'($urandom);
      cfg_bank_mask = NUM_BANKS'($urandom);
      in_valid      = (sidx < nstream) && pct(in_pct);
      in_data       = (sidx < nstream) ? opq[sidx] : rand_vec();
      cmd_ready     = (cyc < cmd_hold) ? 1'b0 : pct(cmd_pct);
      out_ready     = (cyc < out_hold) ? 1'b0 : pct(out_pct);
      if (rspq_t.size() > 0 && rspq_t[0] == edges) begin
        rsp_valid = 1'b1;
        rsp_data  = rspq_d.pop_front();
        void'(rspq_t.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = rand_vec();
      end

      @(negedge clk);
      if (cyc == out_hold - 1) cv_at_release = int'(cmd_valid);

      if (cmd_valid && cmd_ready) begin
        checks++;
        if (cmd_zone !== zone || cmd_bank_mask !== mask) begin
          errs++;
          $display("FAIL cmd_cfg: zone/mask got %0h/%0h want %0h/%0h", cmd_zone, cmd_bank_mask, zone, mask);
        end
        if (cmd_op == 2'b10) begin
          ea = (base + nrd) % ROWS;
          checks++;
          if (nrd >= len || int'(cmd_addr) != ea) begin
            errs++;
            $display("FAIL read_cmd: read #%0d addr got %0d want %0d (len %0d)", nrd, cmd_addr, ea, len);
          end
          rspq_d.push_back(acc_mem[cmd_addr]);
          rspq_t.push_back(edges + lat);
          nrd++;
        end else begin
          k   = nwr + nac;
          p   = k / len;
          r   = k % len;
          ea  = (base + r) % ROWS;
          eop = (p == 0) ? 0 : 1;
          checks++;
          if (int'(cmd_op) != eop || int'(cmd_addr) != ea || k >= nstream) begin
            errs++;
            $display("FAIL wa_cmd: cmd #%0d op/addr got %0d/%0d want %0d/%0d", k, cmd_op, cmd_addr, eop, ea);
          end else begin
            checks++;
            if (cmd_wdata !== opq[k]) begin
              errs++;
              $display("FAIL wdata: cmd #%0d got %h want %h", k, cmd_wdata, opq[k]);
            end
          end
          if (cmd_op == 2'b00) begin
            acc_mem[cmd_addr] = cmd_wdata;
            nwr++;
          end else begin
            acc_mem[cmd_addr] = bank_add(acc_mem[cmd_addr], cmd_wdata);
            nac++;
          end
        end
      end

      if (in_valid && in_ready) sidx++;

      if (out_valid && out_ready) begin
        if (reads_before_pop < 0) reads_before_pop = nrd;
        checks++;
        if (ridx >= len) begin
          errs++;
          $display("FAIL extra_result: result #%0d beyond len %0d", ridx, len);
        end else begin
          if (out_data !== expv[ridx]) begin
            errs++;
            $display("FAIL out_data: row %0d got %h want %h", ridx, out_data, expv[ridx]);
          end
          checks++;
          if (out_last !== (ridx == len - 1)) begin
            errs++;
            $display("FAIL out_last: row %0d got %b want %b", ridx, out_last, (ridx == len - 1));
          end
        end
        ridx++;
      end

      if (done) begin
        fin        = 1'b1;
        busy_edges = edges + 1 - e0;
      end
      tick();
    end

    idle_inputs();
    checks++;
    if (!fin) begin
      errs++;
      $display("FAIL job_timeout: done got 0 want 1 (len %0d passes %0d)", len, passes);
    end
    checks++;
    if (nwr != len || nac != (np - 1) * len || nrd != len || sidx != nstream) begin
      errs++;
      $display("FAIL cmd_counts: wr/acc/rd/consumed got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               nwr, nac, nrd, sidx, len, (np - 1) * len, len, nstream);
    end
    checks++;
    if (ridx != len) begin
      errs++;
      $display("FAIL result_count: got %0d want %0d", ridx, len);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL after_done: done/busy got %b/%b want 0/0", done, busy);
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if ({busy, done, cmd_valid, in_ready, out_valid, out_last} !== 6'b0 ||
        cmd_addr !== '0 || cmd_wdata !== '0 || cmd_op !== 2'b00 ||
        cmd_zone !== '0 || cmd_bank_mask !== '0 ||
        perf_busy_cycles !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      errs++;
      $display("FAIL %s: busy/done/cv/ir/ov/ol got %b%b%b%b%b%b addr %0d op %0d want all 0",
               tag, busy, done, cmd_valid, in_ready, out_valid, out_last, cmd_addr, cmd_op);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn      = 1'b0;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand_vec();
    rsp_valid = 1'b1;
    rsp_data  = rand_vec();
    cfg_len   = (ADDR_WIDTH+1)'(4);
    tick();
    tick();
    check_quiet("reset_during");
    idle_inputs();
    rstn = 1'b1;
    tick();
    check_quiet("reset_after");
  endtask

  task automatic test_basic();
    int a, b, c;
    run_job(0, 4, 3, 2, 100, 100, 100, 0, 0, 1'b1, a, b, c);
  endtask

  task automatic test_addr_wrap();
    int a, b, c;
    run_job(510, 4, 3, 3, 70, 70, 80, 0, 0, 1'b0, a, b, c);
  endtask

  task automatic test_random();
    int a, b, c;
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(ROWS - 1, 0)), int'($urandom_range(12, 1)), int'($urandom_range(4, 0)),
              int'($urandom_range(4, 1)), int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
              int'($urandom_range(100, 40)), 0, 0, 1'b0, a, b, c);
  endtask

  task automatic test_backpressure();
    int rbp, cv, be;
    run_job(3, 8, 1, 2, 100, 100, 100, 0, 40, 1'b0, rbp, cv, be);
    checks++;
    if (rbp != RD_FIFO_DEPTH) begin
      errs++;
      $display("FAIL bp_reads: reads before first pop got %0d want %0d", rbp, RD_FIFO_DEPTH);
    end
    checks++;
    if (cv != 0) begin
      errs++;
      $display("FAIL bp_cmd_valid: cmd_valid while full got %0d want 0", cv);
    end
  endtask

  task automatic test_zero_len();
    idle_inputs();
    cfg_base   = ADDR_WIDTH'(17);
    cfg_len    = '0;
    cfg_passes = 8'd2;
    start      = 1'b1;
    in_valid   = 1'b1;
    cmd_ready  = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL zero_len_done: done/busy/cmd_valid got %b/%b/%b want 1/1/0", done, busy, cmd_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL zero_len_idle: done/busy/cmd_valid got %b/%b/%b want 0/0/0", done, busy, cmd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit seen_ov, seen_done;
    idle_inputs();
    cfg_base   = '0;
    cfg_len    = (ADDR_WIDTH+1)'(4);
    cfg_passes = 8'd3;
    start      = 1'b1;
    in_valid   = 1'b1;
    in_data    = rand_vec();
    cmd_ready  = 1'b1;
    out_ready  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b1 || cmd_op !== 2'b01) begin
      errs++;
      $display("FAIL mid_accum: busy/op got %b/%0d want 1/1", busy, cmd_op);
    end
    rstn = 1'b0;
    tick();
    rstn     = 1'b1;
    in_valid = 1'b0;
    checks++;
    if ({busy, done, cmd_valid, in_ready, out_valid} !== 5'b0) begin
      errs++;
      $display("FAIL mid_reset: busy/done/cv/ir/ov got %b%b%b%b%b want 00000",
               busy, done, cmd_valid, in_ready, out_valid);
    end
    rsp_valid = 1'b1;
    rsp_data  = rand_vec();
    tick();
    rsp_valid = 1'b0;
    seen_ov   = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_ov   |= out_valid;
      seen_done |= done;
      tick();
    end
    checks++;
    if (seen_ov || seen_done) begin
      errs++;
      $display("FAIL stray_rsp: out_valid/done seen got %b/%b want 0/0", seen_ov, seen_done);
    end
    idle_inputs();
  endtask

  task automatic test_perf();
    int a, b, be;
    run_job(7, 2, 1, 2, 100, 100, 100, 5, 0, 1'b0, a, b, be);
`ifdef ACCUM_SEQ_PERF_EN
    checks++;
    if (perf_stall_cycles !== 32'd5) begin
      errs++;
      $display("FAIL perf_stall: got %0d want 5", perf_stall_cycles);
    end
    checks++;
    if (perf_busy_cycles !== 32'(be)) begin
      errs++;
      $display("FAIL perf_busy: got %0d want %0d", perf_busy_cycles, be);
    end
`else
    checks++;
    if (perf_stall_cycles !== 32'd0 || perf_busy_cycles !== 32'd0) begin
      errs++;
      $display("FAIL perf_off: busy/stall got %0d/%0d want 0/0", perf_busy_cycles, perf_stall_cycles);
    end
`endif
  endtask

  initial begin
    rstn          = 1'b0;
    cfg_base      = '0;
    cfg_len       = '0;
    cfg_passes    = '0;
    cfg_zone      = '0;
    cfg_bank_mask = '0;
    in_data       = '0;
    rsp_data      = '0;
    idle_inputs();
    test_reset();
    test_basic();
    test_addr_wrap();
    test_random();
    test_backpressure();
    test_zero_len();
    test_perf();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
